// File: rtl/t05_huff_node_builder.sv
// Huffman tree-build stage: wipes the two chosen histogram entries, writes the pair sum as a new internal node, stores the node record.
// Latency: start to done is 5 cycles with both readies high; the root and error paths take 1 cycle.
// Backpressure: each write is held with address and data stable until its ready is seen; en_state != EN_CODE freezes everything.
// Optional build macro T05_HNB_CHECK_EN adds id sanity checks at start acceptance.
module t05_huff_node_builder #(
    parameter int NODE_BASE = 256,
    parameter int MAX_NODES = 128,
    parameter int EN_CODE   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  en_state,
    input  logic        start,
    input  logic        pair_valid,
    input  logic [8:0]  least1,
    input  logic [8:0]  least2,
    input  logic [63:0] sum,
    output logic        hist_wr_en,
    output logic [8:0]  hist_addr,
    output logic [63:0] hist_wdata,
    input  logic        hist_wr_ready,
    output logic        node_wr_en,
    output logic [6:0]  node_addr,
    output logic [81:0] node_wdata,
    input  logic        node_wr_ready,
    output logic [7:0]  node_count,
    output logic [8:0]  root_node,
    output logic        done,
    output logic        tree_done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WIPE1  = 3'd1,
        S_WIPE2  = 3'd2,
        S_SUMWR  = 3'd3,
        S_NODEWR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  l1_q, l1_d;
    logic [8:0]  l2_q, l2_d;
    logic [63:0] sum_q, sum_d;
    logic [7:0]  nc_q, nc_d;
    logic [8:0]  root_q, root_d;
    logic        tdone_q, tdone_d;
    logic        err_q, err_d;

    logic        hist_en_q, hist_en_d;
    logic [8:0]  hist_addr_q, hist_addr_d;
    logic [63:0] hist_wdata_q, hist_wdata_d;
    logic        node_en_q, node_en_d;
    logic [6:0]  node_addr_q, node_addr_d;
    logic [81:0] node_wdata_q, node_wdata_d;
    logic        done_q, done_d;

    logic        active;
    logic        chk_fail;

    // Node id to histogram address: internal nodes live above the character entries.
    function automatic logic [8:0] id_addr(input logic [8:0] id);
        if (id[8]) begin
            return 9'(NODE_BASE) + {1'b0, id[7:0]};
        end
        return {1'b0, id[7:0]};
    endfunction

    assign active = (en_state == 4'(EN_CODE));

`ifdef T05_HNB_CHECK_EN
    // Reject a degenerate pair or a reference to an internal node not yet built.
    assign chk_fail = (least1 == least2)
                    || (least1[8] && (least1[7:0] >= nc_q))
                    || (least2[8] && (least2[7:0] >= nc_q));
`else
    assign chk_fail = 1'b0;
`endif

    // Next-state logic plus next values of the registered write ports.
    always_comb begin
        state_d = state_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        sum_d   = sum_q;
        nc_d    = nc_q;
        root_d  = root_q;
        tdone_d = tdone_q;
        err_d   = err_q;

        if (active) begin
            case (state_q)
                S_IDLE: begin
                    if (start && !tdone_q && !err_q) begin
                        l1_d  = least1;
                        l2_d  = least2;
                        sum_d = sum;
                        if (!pair_valid) begin
                            root_d  = least1;
                            tdone_d = 1'b1;
                            state_d = S_DONE;
                        end else if (nc_q == 8'(MAX_NODES) || chk_fail) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WIPE1;
                        end
                    end
                end
                S_WIPE1:  if (hist_wr_ready) state_d = S_WIPE2;
                S_WIPE2:  if (hist_wr_ready) state_d = S_SUMWR;
                S_SUMWR:  if (hist_wr_ready) state_d = S_NODEWR;
                S_NODEWR: begin
                    if (node_wr_ready) begin
                        nc_d    = nc_q + 8'd1;
                        state_d = S_DONE;
                    end
                end
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        // Ports follow the state being entered, so they are flop outputs and
        // stay put whenever the state does (stall or freeze).
        hist_en_d    = 1'b0;
        hist_addr_d  = 9'd0;
        hist_wdata_d = 64'd0;
        node_en_d    = 1'b0;
        node_addr_d  = 7'd0;
        node_wdata_d = 82'd0;
        done_d       = 1'b0;
        case (state_d)
            S_WIPE1: begin
                hist_en_d   = 1'b1;
                hist_addr_d = id_addr(l1_d);
            end
            S_WIPE2: begin
                hist_en_d   = 1'b1;
                hist_addr_d = id_addr(l2_d);
            end
            S_SUMWR: begin
                hist_en_d    = 1'b1;
                hist_addr_d  = 9'(NODE_BASE) + {1'b0, nc_d};
                hist_wdata_d = sum_d;
            end
            S_NODEWR: begin
                node_en_d    = 1'b1;
                node_addr_d  = nc_d[6:0];
                node_wdata_d = {l1_d, l2_d, sum_d};
            end
            S_DONE:  done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // State, latched request and registered outputs; synchronous reset clears all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            l1_q         <= 9'd0;
            l2_q         <= 9'd0;
            sum_q        <= 64'd0;
            nc_q         <= 8'd0;
            root_q       <= 9'd0;
            tdone_q      <= 1'b0;
            err_q        <= 1'b0;
            hist_en_q    <= 1'b0;
            hist_addr_q  <= 9'd0;
            hist_wdata_q <= 64'd0;
            node_en_q    <= 1'b0;
            node_addr_q  <= 7'd0;
            node_wdata_q <= 82'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            l1_q         <= l1_d;
            l2_q         <= l2_d;
            sum_q        <= sum_d;
            nc_q         <= nc_d;
            root_q       <= root_d;
            tdone_q      <= tdone_d;
            err_q        <= err_d;
            hist_en_q    <= hist_en_d;
            hist_addr_q  <= hist_addr_d;
            hist_wdata_q <= hist_wdata_d;
            node_en_q    <= node_en_d;
            node_addr_q  <= node_addr_d;
            node_wdata_q <= node_wdata_d;
            done_q       <= done_d;
        end
    end

    assign hist_wr_en = hist_en_q;
    assign hist_addr  = hist_addr_q;
    assign hist_wdata = hist_wdata_q;
    assign node_wr_en = node_en_q;
    assign node_addr  = node_addr_q;
    assign node_wdata = node_wdata_q;
    assign node_count = nc_q;
    assign root_node  = root_q;
    assign done       = done_q;
    assign tree_done  = tdone_q;
    assign err        = err_q;

endmodule

// File: tb/tb_t05_huff_node_builder.sv
module tb_t05_huff_node_builder;

    localparam logic [3:0] EN = 4'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en_state;
    logic        start;
    logic        pair_valid;
    logic [8:0]  least1;
    logic [8:0]  least2;
    logic [63:0] sum;
    logic        hist_wr_en;
    logic [8:0]  hist_addr;
    logic [63:0] hist_wdata;
    logic        hist_wr_ready;
    logic        node_wr_en;
    logic [6:0]  node_addr;
    logic [81:0] node_wdata;
    logic        node_wr_ready;
    logic [7:0]  node_count;
    logic [8:0]  root_node;
    logic        done;
    logic        tree_done;
    logic        err;

    always #5 clk = ~clk;

    t05_huff_node_builder dut (
        .clk(clk), .rst(rst), .en_state(en_state), .start(start),
        .pair_valid(pair_valid), .least1(least1), .least2(least2), .sum(sum),
        .hist_wr_en(hist_wr_en), .hist_addr(hist_addr), .hist_wdata(hist_wdata),
        .hist_wr_ready(hist_wr_ready), .node_wr_en(node_wr_en), .node_addr(node_addr),
        .node_wdata(node_wdata), .node_wr_ready(node_wr_ready), .node_count(node_count),
        .root_node(root_node), .done(done), .tree_done(tree_done), .err(err)
    );

    typedef struct {
        logic        is_node;
        logic [8:0]  addr;
        logic [81:0] data;
    } wr_t;

    typedef struct {
        bit          pv;
        logic [8:0]  l1;
        logic [8:0]  l2;
        logic [63:0] s;
        int          lat;
        int          nc;
        bit          td;
        logic [8:0]  root;
    } vec_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Reference model state
    int         m_nc;
    bit         m_td;
    bit         m_err;
    logic [8:0] m_root;
    bit         rnd = 1'b0;

    logic        prev_hhold, prev_nhold;
    logic [8:0]  prev_haddr;
    logic [63:0] prev_hdata;
    logic [6:0]  prev_naddr;
    logic [81:0] prev_ndata;

    task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] haddr(input logic [8:0] id);
        int a;
        a = id[8] ? 256 + int'(id[7:0]) : int'(id[7:0]);
        return 9'(a);
    endfunction

    function automatic bit ids_bad(input logic [8:0] l1, input logic [8:0] l2);
`ifdef T05_HNB_CHECK_EN
        return (l1 == l2) || (l1[8] && int'(l1[7:0]) >= m_nc) || (l2[8] && int'(l2[7:0]) >= m_nc);
`else
        return 1'b0;
`endif
    endfunction

    // Outcome of one request: the list of writes and the nominal start-to-done latency.
    task automatic model_txn(input bit pv, input logic [8:0] l1, input logic [8:0] l2,
                             input logic [63:0] s, output bit ign, output int lat);
        exp_q.delete();
        ign = 1'b0;
        lat = 1;
        if (m_td || m_err) begin
            ign = 1'b1;
            lat = 0;
        end else if (!pv) begin
            m_root = l1;
            m_td   = 1'b1;
        end else if (m_nc == 128 || ids_bad(l1, l2)) begin
            m_err = 1'b1;
        end else begin
            exp_q.push_back('{1'b0, haddr(l1), 82'd0});
            exp_q.push_back('{1'b0, haddr(l2), 82'd0});
            exp_q.push_back('{1'b0, 9'(256 + m_nc), {18'd0, s}});
            exp_q.push_back('{1'b1, 9'(m_nc), {l1, l2, s}});
            m_nc++;
            lat = 5;
        end
    endtask

    // Write-port monitor: records accepted writes, checks holding and exclusivity.
    always @(negedge clk) begin
        if (rst) begin
            prev_hhold = 1'b0;
            prev_nhold = 1'b0;
        end else begin
            if (prev_hhold)
                chk("hist_hold", {hist_wr_en, hist_addr, hist_wdata}, {1'b1, prev_haddr, prev_hdata});
            if (prev_nhold)
                chk("node_hold", {node_wr_en, node_addr, node_wdata}, {1'b1, prev_naddr, prev_ndata});
            if (hist_wr_en || node_wr_en)
                chk("wr_excl", hist_wr_en & node_wr_en, 82'd0);
            if (en_state == EN && hist_wr_en && hist_wr_ready)
                got_q.push_back('{1'b0, hist_addr, {18'd0, hist_wdata}});
            if (en_state == EN && node_wr_en && node_wr_ready)
                got_q.push_back('{1'b1, {2'b00, node_addr}, node_wdata});
            prev_hhold = hist_wr_en && (!hist_wr_ready || en_state != EN);
            prev_nhold = node_wr_en && (!node_wr_ready || en_state != EN);
            prev_haddr = hist_addr;
            prev_hdata = hist_wdata;
            prev_naddr = node_addr;
            prev_ndata = node_wdata;
        end
    end

    task automatic set_ctl(input int i, input int hmask, input int emask);
        if (rnd) begin
            hist_wr_ready = ($urandom % 4) != 0;
            node_wr_ready = ($urandom % 4) != 0;
            en_state      = ($urandom % 8 == 0) ? 4'd0 : EN;
        end else begin
            hist_wr_ready = !(i < 32 && hmask[i]);
            node_wr_ready = 1'b1;
            en_state      = (i < 32 && emask[i]) ? 4'd0 : EN;
        end
        if (i == 0) en_state = EN;
    endtask

    task automatic reset_dut();
        rst = 1'b1; start = 1'b0; en_state = EN; pair_valid = 1'b0;
        least1 = 9'd0; least2 = 9'd0; sum = 64'd0;
        hist_wr_ready = 1'b1; node_wr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_nc = 0; m_td = 1'b0; m_err = 1'b0; m_root = 9'd0;
    endtask

    // One start request; extra = stall/freeze cycles added to the nominal latency.
    task automatic run_txn(input bit pv, input logic [8:0] l1, input logic [8:0] l2,
                           input logic [63:0] s, input int hmask, input int emask,
                           input int extra, output int lat_o);
        bit ign;
        int mlat;
        bit seen;
        int n;
        model_txn(pv, l1, l2, s, ign, mlat);
        got_q.delete();
        pair_valid = pv; least1 = l1; least2 = l2; sum = s; start = 1'b1;
        set_ctl(0, hmask, emask);
        seen = 1'b0;
        lat_o = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat_o = i;
                break;
            end
            if (ign && i >= 8) break;
            set_ctl(i, hmask, emask);
        end
        en_state = EN; hist_wr_ready = 1'b1; node_wr_ready = 1'b1;
        if (ign) begin
            chk("ignored_no_done", seen, 82'd0);
        end else begin
            chk("done_seen", seen, 82'd1);
            if (seen && !rnd) chk("latency", lat_o, mlat + extra);
        end
        tick();
        chk("done_pulse", done, 82'd0);
        chk("wr_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk("wr_kind", got_q[k].is_node, exp_q[k].is_node);
            chk("wr_addr", got_q[k].addr, exp_q[k].addr);
            chk("wr_data", got_q[k].data, exp_q[k].data);
        end
        chk("node_count", node_count, 82'(m_nc));
        chk("tree_done", tree_done, m_td);
        chk("err", err, m_err);
        chk("root_node", root_node, m_root);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int   lat;
        bit   pv;
        logic [8:0] a, b;

        tbl[0] = '{1'b1, 9'h041, 9'h042, 64'd7,  5, 1, 1'b0, 9'h000};
        tbl[1] = '{1'b1, 9'h100, 9'h043, 64'd20, 5, 2, 1'b0, 9'h000};
        tbl[2] = '{1'b1, 9'h0FF, 9'h101, 64'd33, 5, 3, 1'b0, 9'h000};
        tbl[3] = '{1'b0, 9'h102, 9'h000, 64'd0,  1, 3, 1'b1, 9'h102};
        tbl[4] = '{1'b1, 9'h001, 9'h002, 64'd5,  0, 3, 1'b1, 9'h102};

        reset_dut();
        chk("rst_hist_en", hist_wr_en, 82'd0);
        chk("rst_node_en", node_wr_en, 82'd0);
        chk("rst_hist_addr", hist_addr, 82'd0);
        chk("rst_node_wdata", node_wdata, 82'd0);
        chk("rst_done", done, 82'd0);
        chk("rst_tree_done", tree_done, 82'd0);
        chk("rst_err", err, 82'd0);
        chk("rst_node_count", node_count, 82'd0);
        chk("rst_root", root_node, 82'd0);

        // Table: normal pairs, root identification, request after tree_done ignored
        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].pv, tbl[i].l1, tbl[i].l2, tbl[i].s, 0, 0, 0, lat);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_node_count", node_count, 82'(tbl[i].nc));
            chk("tbl_tree_done", tree_done, tbl[i].td);
            chk("tbl_root", root_node, tbl[i].root);
        end

        // Histogram ready low for 3 cycles while wiping least2
        reset_dut();
        run_txn(1'b1, 9'h041, 9'h042, 64'd7, 32'h1C, 0, 3, lat);
        chk("stall_latency", lat, 82'd8);

        // en_state dropped for 4 cycles during the sum write
        run_txn(1'b1, 9'h003, 9'h100, 64'hDEAD_BEEF_0000_0011, 0, 32'h78, 4, lat);
        chk("freeze_latency", lat, 82'd9);

        // Reset in the middle of the node write
        reset_dut();
        pair_valid = 1'b1; least1 = 9'h011; least2 = 9'h012; sum = 64'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_nodewr_en", node_wr_en, 82'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_node_en", node_wr_en, 82'd0);
        chk("rst_mid_hist_en", hist_wr_en, 82'd0);
        chk("rst_mid_node_count", node_count, 82'd0);
        chk("rst_mid_done", done, 82'd0);
        m_nc = 0; m_td = 1'b0; m_err = 1'b0; m_root = 9'd0;
        run_txn(1'b1, 9'h011, 9'h012, 64'd9, 0, 0, 0, lat);

        // Identical ids / not-yet-built internal id (error only with the check build)
        reset_dut();
        run_txn(1'b1, 9'h010, 9'h010, 64'd4, 0, 0, 0, lat);
        reset_dut();
        run_txn(1'b1, 9'h100, 9'h001, 64'd4, 0, 0, 0, lat);

        // Fill to capacity, then overflow, then ignored
        reset_dut();
        for (int i = 0; i < 128; i++)
            run_txn(1'b1, {1'b0, 8'(i)}, {1'b0, 8'(i + 1)}, 64'(i * 3 + 1), 0, 0, 0, lat);
        chk("full_node_count", node_count, 82'd128);
        run_txn(1'b1, 9'h020, 9'h021, 64'd50, 0, 0, 0, lat);
        chk("overflow_err", err, 82'd1);
        chk("overflow_latency", lat, 82'd1);
        run_txn(1'b0, 9'h020, 9'h000, 64'd0, 0, 0, 0, lat);

        // Random requests with random backpressure and freezes
        rnd = 1'b1;
        reset_dut();
        for (int t = 0; t < 80; t++) begin
            if (m_td || m_err) reset_dut();
            pv = ($urandom % 12) != 0;
            a = ($urandom % 3 == 0 && m_nc > 0) ? {1'b1, 8'($urandom % m_nc)} : {1'b0, 8'($urandom)};
            b = ($urandom % 3 == 0 && m_nc > 0) ? {1'b1, 8'($urandom % m_nc)} : {1'b0, 8'($urandom)};
            run_txn(pv, a, b, {$urandom, $urandom}, 0, 0, 0, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
